nextpc_btb_unit: RTL and testbench

//  Fetch-stage next-PC generator, successor of the stateless next-PC mux. Holds a parametrised

---
 rtl/nextpc_btb_unit_pkg.sv | 62 ++++++
 rtl/nextpc_btb_unit_if.sv | 36 +++
 rtl/nextpc_btb_unit_btb_table.sv | 71 +++++++
 rtl/nextpc_btb_unit.sv | 144 ++++++++++++++
 tb/tb_nextpc_btb_unit.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nextpc_btb_unit_pkg.sv
// -----------------------------------------------------------------------------
// nextpc_btb_unit_pkg
//   Shared definitions for the fetch-stage next-PC unit: RISC-V opcode fields
//   for the control instructions, EX/MEM resolution type encodings, link
//   register numbers and small decode / counter helpers.
// -----------------------------------------------------------------------------
package nextpc_btb_unit_pkg;

  // Opcode field inst[6:2] of the control-transfer instructions.
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // Link registers recognised for call/return hinting.
  localparam logic [4:0] REG_X0 = 5'd0;
  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  // Resolution type reported by the EX/MEM stage.
  typedef enum logic [1:0] {
    EM_OTHER  = 2'd0,
    EM_JALR   = 2'd1,
    EM_BRANCH = 2'd2,
    EM_JAL    = 2'd3
  } em_type_e;

  typedef struct packed {
    logic       is_jal;
    logic       is_jalr;
    logic [4:0] rd;
    logic [4:0] rs1;
  } ctl_decode_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

  // Only 32-bit encodings (quadrant 2'b11) are control instructions; JALR
  // additionally requires funct3 == 0.
  function automatic ctl_decode_t decode_ctl(input logic [31:0] inst);
    ctl_decode_t d;
    d.is_jal  = (inst[1:0] == 2'b11) && (inst[6:2] == OPC_JAL);
    d.is_jalr = (inst[1:0] == 2'b11) && (inst[6:2] == OPC_JALR) && (inst[14:12] == 3'b000);
    d.rd      = inst[11:7];
    d.rs1     = inst[19:15];
    return d;
  endfunction

  // J-type immediate as a 21-bit two's-complement byte offset.
  function automatic logic [20:0] j_imm(input logic [31:0] inst);
    return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/nextpc_btb_unit_if.sv
// -----------------------------------------------------------------------------
// nextpc_btb_unit_if
//   Fetch and resolution bus of the next-PC unit.
//   master : pipeline side -- drives fetch state (stall/inst/current_pc) and the
//            EX/MEM resolution (em_*), receives nextpc/pred_taken/flush.
//   slave  : next-PC unit side.
// -----------------------------------------------------------------------------
interface nextpc_btb_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic [31:0]     inst;
  logic [XLEN-1:0] current_pc;
  logic            em_valid;
  logic [1:0]      em_type;
  logic [XLEN-1:0] em_pc;
  logic            em_taken;
  logic [XLEN-1:0] em_baddr;
  logic            em_guess;
  logic [XLEN-1:0] em_pred_target;
  logic [XLEN-1:0] nextpc;
  logic            pred_taken;
  logic            flush;

  modport master (
    output stall, inst, current_pc,
    output em_valid, em_type, em_pc, em_taken, em_baddr, em_guess, em_pred_target,
    input  nextpc, pred_taken, flush
  );

  modport slave (
    input  stall, inst, current_pc,
    input  em_valid, em_type, em_pc, em_taken, em_baddr, em_guess, em_pred_target,
    output nextpc, pred_taken, flush
  );
endinterface

// File: rtl/nextpc_btb_unit_btb_table.sv
// -----------------------------------------------------------------------------
// nextpc_btb_unit_btb_table
//   Direct-mapped branch target buffer, ENTRIES x {valid, tag, target, cnt}.
//   Ports:
//     clk, rst                synchronous active-high reset
//     rd_idx/rd_tag           combinational lookup -> rd_hit, rd_taken, rd_target
//     wr_en/wr_idx/wr_tag     resolution update of one entry
//     wr_taken/wr_target      actual direction and target of the resolved op
//   The lookup returns registered state only, so a same-cycle update to the
//   same index becomes visible on the following cycle.
// -----------------------------------------------------------------------------
module nextpc_btb_unit_btb_table
  import nextpc_btb_unit_pkg::*;
#(
  parameter int         XLEN     = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CNT_INIT = 2'b01,
  localparam int        IDX_W    = $clog2(ENTRIES),
  localparam int        TAG_W    = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic             rd_taken,
  output logic [XLEN-1:0]  rd_target,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_taken,
  input  logic [XLEN-1:0]  wr_target
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];

  logic wr_hit;

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken  = cnt_q[rd_idx][1];
  assign rd_target = target_q[rd_idx];

  assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // NOTE: tag/target storage is deliberately left out of reset; an entry is
  // qualified by its valid bit, so only valid and the counters are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else if (wr_en) begin
      if (wr_taken) begin
        target_q[wr_idx] <= wr_target;
        if (wr_hit) begin
          cnt_q[wr_idx] <= sat_inc(cnt_q[wr_idx]);
        end else begin
          // Taken miss: allocate, evicting any alias, as weakly taken.
          valid_q[wr_idx] <= 1'b1;
          tag_q[wr_idx]   <= wr_tag;
          cnt_q[wr_idx]   <= 2'b10;
        end
      end else if (wr_hit) begin
        cnt_q[wr_idx] <= sat_dec(cnt_q[wr_idx]);
      end
    end
  end

endmodule

// File: rtl/nextpc_btb_unit.sv
// -----------------------------------------------------------------------------
// nextpc_btb_unit
//   Fetch-stage next-PC generator with a direct-mapped BTB (2-bit counters)
//   and a circular return-address stack.
//   Ports:
//     clk, rst  rising-edge clock, synchronous active-high reset
//     bus       nextpc_btb_unit_if.slave:
//                 stall/inst/current_pc           fetch state
//                 em_valid/em_type/em_pc/em_taken/em_baddr/em_guess/em_pred_target
//                                                 EX/MEM resolution
//                 nextpc/pred_taken/flush         prediction and redirect
//   nextpc priority: reset > mispredict repair > stall > RAS return
//   > BTB taken hit > decoded JAL > sequential. All PC arithmetic wraps.
// -----------------------------------------------------------------------------
module nextpc_btb_unit
  import nextpc_btb_unit_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter int              RAS_DEPTH   = 4,
  parameter logic [1:0]      CNT_INIT    = 2'b01,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input logic               clk,
  input logic               rst,
  nextpc_btb_unit_if.slave  bus
);

  localparam int              IDX_W    = $clog2(BTB_ENTRIES);
  localparam int              TAG_W    = XLEN - IDX_W - 2;
  localparam int              RAS_W    = $clog2(RAS_DEPTH);
  localparam logic [RAS_W-1:0] PTR_ONE  = RAS_W'(1);
  localparam logic [RAS_W:0]   CNT_ONE  = (RAS_W + 1)'(1);
  localparam logic [RAS_W:0]   RAS_FULL = (RAS_W + 1)'(RAS_DEPTH);
  localparam logic [XLEN-1:0]  ADD4     = XLEN'(4);

  // ---------------------------------------------------------------- decode
  ctl_decode_t     dec;
  logic            call_form;
  logic            ret_form;
  logic            ret_pred;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jal_target;
  logic [20:0]     jimm;

  assign dec        = decode_ctl(bus.inst);
  assign jimm       = j_imm(bus.inst);
  assign pc_plus4   = bus.current_pc + ADD4;
  assign jal_target = bus.current_pc + {{(XLEN-21){jimm[20]}}, jimm};

  // A JALR linking through x1/x5 while reading x1/x5 both pops and pushes.
  assign call_form = (dec.is_jal || dec.is_jalr) && is_link(dec.rd);
  assign ret_form  = dec.is_jalr && is_link(dec.rs1) &&
                     ((dec.rd == REG_X0) || is_link(dec.rd));

  // ------------------------------------------------------------- mispredict
  logic mispredict;

  assign mispredict = bus.em_valid && (em_type_e'(bus.em_type) != EM_OTHER) &&
                      ((bus.em_taken != bus.em_guess) ||
                       (bus.em_taken && (bus.em_baddr != bus.em_pred_target)));

  // -------------------------------------------------------------------- BTB
  logic            btb_hit;
  logic            btb_taken;
  logic [XLEN-1:0] btb_target;

  nextpc_btb_unit_btb_table #(
    .XLEN     (XLEN),
    .ENTRIES  (BTB_ENTRIES),
    .CNT_INIT (CNT_INIT)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (bus.current_pc[IDX_W+1:2]),
    .rd_tag    (bus.current_pc[XLEN-1:IDX_W+2]),
    .rd_hit    (btb_hit),
    .rd_taken  (btb_taken),
    .rd_target (btb_target),
    .wr_en     (bus.em_valid && (em_type_e'(bus.em_type) != EM_OTHER)),
    .wr_idx    (bus.em_pc[IDX_W+1:2]),
    .wr_tag    (bus.em_pc[XLEN-1:IDX_W+2]),
    .wr_taken  (bus.em_taken),
    .wr_target (bus.em_baddr)
  );

  // -------------------------------------------------------------------- RAS
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];
  logic [RAS_W-1:0] ras_ptr_q;   // next free slot; top is ras_ptr_q-1
  logic [RAS_W:0]   ras_cnt_q;
  logic [RAS_W-1:0] ras_top_idx;
  logic             ras_nonempty;

  assign ras_top_idx  = ras_ptr_q - PTR_ONE;
  assign ras_nonempty = (ras_cnt_q != '0);
  assign ret_pred     = dec.is_jalr && is_link(dec.rs1) && (dec.rd == REG_X0) && ras_nonempty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (!bus.stall && !mispredict) begin
      if (call_form && ret_form && ras_nonempty) begin
        ras_q[ras_top_idx] <= pc_plus4;               // pop+push: replace top
      end else if (call_form) begin
        ras_q[ras_ptr_q] <= pc_plus4;                 // full: overwrites oldest
        ras_ptr_q        <= ras_ptr_q + PTR_ONE;
        if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + CNT_ONE;
      end else if (ret_form && ras_nonempty) begin
        ras_ptr_q <= ras_top_idx;
        ras_cnt_q <= ras_cnt_q - CNT_ONE;
      end
    end
  end

  // ------------------------------------------------------------- next-PC mux
  // NOTE: every output gets a default first so the comb block cannot infer
  // a latch on any priority path.
  always_comb begin
    bus.nextpc     = pc_plus4;
    bus.pred_taken = 1'b0;
    bus.flush      = 1'b0;
    if (rst) begin
      bus.nextpc = RESET_PC;
    end else if (mispredict) begin
      bus.nextpc = bus.em_taken ? bus.em_baddr : (bus.em_pc + ADD4);
      bus.flush  = 1'b1;
    end else if (bus.stall) begin
      bus.nextpc = bus.current_pc;
    end else if (ret_pred) begin
      bus.nextpc     = ras_q[ras_top_idx];
      bus.pred_taken = 1'b1;
    end else if (btb_hit && btb_taken) begin
      bus.nextpc     = btb_target;
      bus.pred_taken = 1'b1;
    end else if (dec.is_jal) begin
      bus.nextpc     = jal_target;
      bus.pred_taken = 1'b1;
    end
  end

endmodule

// File: tb/tb_nextpc_btb_unit.sv
// -----------------------------------------------------------------------------
// tb_nextpc_btb_unit
//   Directed scenarios followed by randomized traffic, each cycle compared
//   against a behavioural model (BTB as slot -> owner-PC records, RAS as a
//   bounded queue).
// -----------------------------------------------------------------------------
module tb_nextpc_btb_unit;

  localparam int          XLEN        = 32;
  localparam int          BTB_ENTRIES = 16;
  localparam int          RAS_DEPTH   = 4;
  localparam logic [31:0] RESET_PC    = 32'h0;
  localparam logic [31:0] ADDI        = 32'h0000_0013;
  localparam logic [31:0] BEQ         = 32'h0000_0463;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nextpc_btb_unit_if #(.XLEN(XLEN)) bus ();

  nextpc_btb_unit #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES),
    .RAS_DEPTH   (RAS_DEPTH),
    .CNT_INIT    (2'b01),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------------------ model
  typedef struct {
    bit          valid;
    logic [31:0] owner;
    logic [31:0] target;
    int          cnt;
  } mentry_t;

  mentry_t     mbtb [BTB_ENTRIES];
  logic [31:0] mras [$];

  function automatic bit link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % BTB_ENTRIES);
  endfunction

  function automatic bit m_mispredict();
    return bus.em_valid && (bus.em_type != 2'd0) &&
           ((bus.em_taken != bus.em_guess) ||
            (bus.em_taken && (bus.em_baddr != bus.em_pred_target)));
  endfunction

  function automatic void model_predict(output logic [31:0] np, output logic pt,
                                        output logic fl);
    logic [31:0] pc;
    logic [31:0] in;
    logic [31:0] off;
    int          s;
    pc = bus.current_pc;
    in = bus.inst;
    np = pc + 32'd4;
    pt = 1'b0;
    fl = 1'b0;
    s  = slot_of(pc);
    if (rst) begin
      np = RESET_PC;
    end else if (m_mispredict()) begin
      np = bus.em_taken ? bus.em_baddr : bus.em_pc + 32'd4;
      fl = 1'b1;
    end else if (bus.stall) begin
      np = pc;
    end else if (in[6:2] == 5'b11001 && link_reg(in[19:15]) && in[11:7] == 5'd0 &&
                 mras.size() > 0) begin
      np = mras[mras.size()-1];
      pt = 1'b1;
    end else if (mbtb[s].valid && mbtb[s].owner[31:2] == pc[31:2] && mbtb[s].cnt >= 2) begin
      np = mbtb[s].target;
      pt = 1'b1;
    end else if (in[6:2] == 5'b11011) begin
      off = {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
      np  = pc + off;
      pt  = 1'b1;
    end
  endfunction

  function automatic void model_update();
    logic [31:0] in;
    int          s;
    bit          hit;
    bit          call;
    bit          ret;
    in = bus.inst;
    if (rst) begin
      foreach (mbtb[i]) mbtb[i].valid = 1'b0;
      mras.delete();
      return;
    end
    if (bus.em_valid && bus.em_type != 2'd0) begin
      s   = slot_of(bus.em_pc);
      hit = mbtb[s].valid && (mbtb[s].owner[31:2] == bus.em_pc[31:2]);
      if (bus.em_taken) begin
        if (hit) begin
          mbtb[s].cnt    = (mbtb[s].cnt < 3) ? mbtb[s].cnt + 1 : 3;
          mbtb[s].target = bus.em_baddr;
        end else begin
          mbtb[s].valid  = 1'b1;
          mbtb[s].owner  = bus.em_pc;
          mbtb[s].target = bus.em_baddr;
          mbtb[s].cnt    = 2;
        end
      end else if (hit) begin
        mbtb[s].cnt = (mbtb[s].cnt > 0) ? mbtb[s].cnt - 1 : 0;
      end
    end
    if (!bus.stall && !m_mispredict()) begin
      call = (in[6:2] == 5'b11011 || in[6:2] == 5'b11001) && link_reg(in[11:7]);
      ret  = (in[6:2] == 5'b11001) && link_reg(in[19:15]) &&
             (in[11:7] == 5'd0 || link_reg(in[11:7]));
      if (ret && mras.size() > 0) void'(mras.pop_back());
      if (call) begin
        mras.push_back(bus.current_pc + 32'd4);
        if (mras.size() > RAS_DEPTH) void'(mras.pop_front());
      end
    end
  endfunction

  // ---------------------------------------------------------------- helpers
  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect3(input string tag, input logic [31:0] np, input logic pt,
                         input logic fl);
    #1;
    check({tag, ".nextpc"}, bus.nextpc, np);
    check({tag, ".pred_taken"}, {31'd0, bus.pred_taken}, {31'd0, pt});
    check({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, fl});
  endtask

  // Compare against the model, advance one clock, then update the model.
  task automatic tick();
    logic [31:0] e_np;
    logic        e_pt;
    logic        e_fl;
    #1;
    model_predict(e_np, e_pt, e_fl);
    check("model.nextpc", bus.nextpc, e_np);
    check("model.pred_taken", {31'd0, bus.pred_taken}, {31'd0, e_pt});
    check("model.flush", {31'd0, bus.flush}, {31'd0, e_fl});
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] in);
    bus.current_pc = pc;
    bus.inst       = in;
  endtask

  task automatic resolve(input logic [1:0] t, input logic [31:0] pc, input logic taken,
                         input logic [31:0] baddr, input logic guess,
                         input logic [31:0] ptgt);
    bus.em_valid       = 1'b1;
    bus.em_type        = t;
    bus.em_pc          = pc;
    bus.em_taken       = taken;
    bus.em_baddr       = baddr;
    bus.em_guess       = guess;
    bus.em_pred_target = ptgt;
  endtask

  task automatic no_resolve();
    bus.em_valid = 1'b0;
    bus.em_type  = 2'd0;
    bus.em_taken = 1'b0;
    bus.em_guess = 1'b0;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'd7;
    endcase
  endfunction

  // --------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] pcv;
    logic [31:0] rnd;
    logic [1:0]  t;

    rst       = 1'b1;
    bus.stall = 1'b0;
    bus.em_pc = '0;
    bus.em_baddr = '0;
    bus.em_pred_target = '0;
    no_resolve();
    fetch(32'h40, ADDI);
    @(negedge clk);

    // Reset holds nextpc at RESET_PC, then sequential fetch.
    expect3("rst0", 32'h0, 1'b0, 1'b0); tick();
    expect3("rst1", 32'h0, 1'b0, 1'b0); tick();
    rst = 1'b0;
    expect3("post_rst", 32'h44, 1'b0, 1'b0); tick();

    // Branch training at 0x100 -> 0x80, then untraining.
    resolve(2'd2, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    expect3("train_mis0", 32'h80, 1'b0, 1'b1); tick();
    expect3("train_mis1", 32'h80, 1'b0, 1'b1); tick();
    no_resolve();
    fetch(32'h100, BEQ);
    expect3("trained", 32'h80, 1'b1, 1'b0); tick();
    fetch(32'h40, ADDI);
    resolve(2'd2, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    expect3("untrain0", 32'h104, 1'b0, 1'b1); tick();
    expect3("untrain1", 32'h104, 1'b0, 1'b1); tick();
    no_resolve();
    fetch(32'h100, BEQ);
    expect3("untrained", 32'h104, 1'b0, 1'b0); tick();

    // Mispredict repair beats stall.
    bus.stall = 1'b1;
    fetch(32'h40, ADDI);
    resolve(2'd2, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    expect3("mis_taken", 32'h300, 1'b0, 1'b1); tick();
    resolve(2'd2, 32'h200, 1'b0, 32'h300, 1'b1, 32'h300);
    expect3("mis_nottaken", 32'h204, 1'b0, 1'b1); tick();
    no_resolve();
    expect3("stall", 32'h40, 1'b0, 1'b0); tick();
    bus.stall = 1'b0;

    // Call / return through the RAS, then overflow.
    fetch(32'h10, enc_jal(5'd1, 21'h100));
    expect3("call", 32'h110, 1'b1, 1'b0); tick();
    fetch(32'h500, enc_jalr(5'd0, 5'd1, 12'h0));
    expect3("ret", 32'h14, 1'b1, 1'b0); tick();
    for (int k = 0; k <= RAS_DEPTH; k++) begin
      fetch(32'h600 + 32'(16 * k), enc_jal(5'd1, 21'h8));
      tick();
    end
    for (int k = 0; k < RAS_DEPTH; k++) begin
      fetch(32'h700, enc_jalr(5'd0, (k % 2 == 1) ? 5'd5 : 5'd1, 12'h0));
      expect3("nested_ret", 32'h644 - 32'(16 * k), 1'b1, 1'b0); tick();
    end
    fetch(32'h700, enc_jalr(5'd0, 5'd1, 12'h0));
    expect3("ras_empty", 32'h704, 1'b0, 1'b0); tick();

    // Aliasing entries evict each other.
    fetch(32'h40, ADDI);
    resolve(2'd2, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    expect3("alias_train", 32'h44, 1'b0, 1'b0); tick();
    no_resolve();
    fetch(32'h100, BEQ);
    expect3("alias_a_hit", 32'h80, 1'b1, 1'b0); tick();
    fetch(32'h40, ADDI);
    resolve(2'd2, 32'h100 + 32'(4 * BTB_ENTRIES), 1'b1, 32'h90, 1'b0, 32'h144);
    expect3("alias_b_mis", 32'h90, 1'b0, 1'b1); tick();
    no_resolve();
    fetch(32'h100 + 32'(4 * BTB_ENTRIES), BEQ);
    expect3("alias_b_hit", 32'h90, 1'b1, 1'b0); tick();
    fetch(32'h100, BEQ);
    expect3("alias_a_evicted", 32'h104, 1'b0, 1'b0); tick();

    // PC wrap.
    fetch(32'hFFFF_FFFC, ADDI);
    expect3("wrap_seq", 32'h0, 1'b0, 1'b0); tick();
    fetch(32'hFFFF_FFF8, enc_jal(5'd0, 21'h10));
    expect3("wrap_jal", 32'h8, 1'b1, 1'b0); tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 249) == 0);
      bus.stall = ($urandom_range(0, 7) == 0);
      pcv = 32'h100 + 32'(4 * $urandom_range(0, 23));
      if ($urandom_range(0, 15) == 0) pcv = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      rnd = $urandom;
      case ($urandom_range(0, 4))
        0:       fetch(pcv, ADDI);
        1:       fetch(pcv, BEQ);
        2:       fetch(pcv, enc_jal(pick_reg(), {rnd[20:1], 1'b0}));
        3:       fetch(pcv, enc_jalr(pick_reg(), pick_reg(), rnd[31:20]));
        default: fetch(pcv, enc_jalr(5'd0, ($urandom_range(0, 1) == 1) ? 5'd5 : 5'd1, 12'h0));
      endcase
      if ($urandom_range(0, 2) != 0) begin
        t = 2'($urandom_range(0, 3));
        resolve(t, 32'h100 + 32'(4 * $urandom_range(0, 23)),
                (t == 2'd1 || t == 2'd3) ? 1'b1 : 1'($urandom_range(0, 1)),
                32'h80 + 32'(16 * $urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                32'h80 + 32'(16 * $urandom_range(0, 3)));
      end else begin
        no_resolve();
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
